ring_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares a single resource among N requesters.
- Priority is held in a one-hot rotating ring pointer, the same structure as the team's ring counter.
- Grants are registered, held until release, and bounded by a maximum hold time.
- Sits between requesting engines and a shared datapath or bus port; owns the grant and the fairness state.

---
 rtl/ring_rr_arbiter.sv | 91 +++++++++
 tb/tb_ring_rr_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with a one-hot ring priority pointer, held grants and a forced-release timeout
module ring_rr_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N-1:0]                  req,
  input  logic [N-1:0]                  mask,
  input  logic                          done,
  output logic [N-1:0]                  grant,
  output logic                          grant_valid,
  output logic [$clog2(N)-1:0]          grant_id,
  output logic [$clog2(MAX_HOLD+1)-1:0] hold_cnt,
  output logic                          timeout
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [N-1:0] ptr, ptr_n, elig, pick, grant_n;
  logic [IW-1:0] ptr_id, pick_id, j, id_n;
  logic [HW-1:0] hold_n;
  logic found, own, over, rel, timeout_n;
  assign elig = req & mask;
  assign own = |(grant & elig);
  assign over = hold_cnt == HW'(MAX_HOLD);
  assign rel = done | ~own | over;
  assign grant_valid = |grant;
  always_comb begin
    ptr_id = '0;
    for (int i = 0; i < N; i++) if (ptr[i]) ptr_id = IW'(i);
  end
  // first eligible requester at or after the pointer, wrapping around the ring
  always_comb begin
    pick = '0;
    pick_id = '0;
    found = 1'b0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr_id) + i) % N);
      if (!found && elig[j]) begin
        found = 1'b1;
        pick[j] = 1'b1;
        pick_id = j;
      end
    end
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    id_n = grant_id;
    hold_n = hold_cnt;
    ptr_n = ptr;
    timeout_n = 1'b0;
    if (state == IDLE) begin
      if (found) begin
        state_n = GRANT;
        grant_n = pick;
        id_n = pick_id;
        hold_n = HW'(1);
        ptr_n = {pick[N-2:0], pick[N-1]};
      end
    end else if (rel) begin
      state_n = IDLE;
      grant_n = '0;
      id_n = '0;
      hold_n = '0;
      timeout_n = over & ~done & own;
    end else begin
      hold_n = hold_cnt + HW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      hold_cnt <= '0;
      timeout <= 1'b0;
      ptr <= N'(1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      grant_id <= id_n;
      hold_cnt <= hold_n;
      timeout <= timeout_n;
      ptr <= ptr_n;
    end
  end
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter: directed vector table plus hand-written timeout and async-reset sequences
module tb_ring_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0, mask = '0;
  logic done = 1'b0;
  logic [3:0] grant, grant1;
  logic grant_valid, grant_valid1, timeout, timeout1;
  logic [1:0] grant_id, grant_id1;
  logic [3:0] hold_cnt;
  logic [0:0] hold_cnt1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ring_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .hold_cnt(hold_cnt), .timeout(timeout)
  );
  ring_rr_arbiter #(.N(4), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .done(done),
    .grant(grant1), .grant_valid(grant_valid1), .grant_id(grant_id1),
    .hold_cnt(hold_cnt1), .timeout(timeout1)
  );
  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic       done;
    logic [3:0] g;
    logic [1:0] id;
    logic [3:0] h;
    logic       to;
  } vec_t;
  vec_t tv[23];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_main(input string nm, input logic [3:0] g, input logic [1:0] id, input logic [3:0] h, input logic to);
    chk({nm, ".grant"}, 32'(grant), 32'(g));
    chk({nm, ".valid"}, 32'(grant_valid), 32'(g != 0));
    chk({nm, ".id"}, 32'(grant_id), 32'(id));
    chk({nm, ".hold"}, 32'(hold_cnt), 32'(h));
    chk({nm, ".timeout"}, 32'(timeout), 32'(to));
  endtask
  initial begin
    tv[0]  = '{4'h1, 4'hF, 1'b0, 4'h1, 2'd0, 4'd1, 1'b0};
    tv[1]  = '{4'h1, 4'hF, 1'b0, 4'h1, 2'd0, 4'd2, 1'b0};
    tv[2]  = '{4'h1, 4'hF, 1'b0, 4'h1, 2'd0, 4'd3, 1'b0};
    tv[3]  = '{4'h1, 4'hF, 1'b1, 4'h0, 2'd0, 4'd0, 1'b0};
    tv[4]  = '{4'hF, 4'hF, 1'b1, 4'h2, 2'd1, 4'd1, 1'b0};
    tv[5]  = '{4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 4'd0, 1'b0};
    tv[6]  = '{4'hF, 4'hF, 1'b1, 4'h4, 2'd2, 4'd1, 1'b0};
    tv[7]  = '{4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 4'd0, 1'b0};
    tv[8]  = '{4'hF, 4'hF, 1'b1, 4'h8, 2'd3, 4'd1, 1'b0};
    tv[9]  = '{4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 4'd0, 1'b0};
    tv[10] = '{4'hF, 4'hF, 1'b1, 4'h1, 2'd0, 4'd1, 1'b0};
    tv[11] = '{4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 4'd0, 1'b0};
    tv[12] = '{4'hF, 4'hF, 1'b1, 4'h2, 2'd1, 4'd1, 1'b0};
    tv[13] = '{4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 4'd0, 1'b0};
    tv[14] = '{4'hA, 4'h2, 1'b0, 4'h2, 2'd1, 4'd1, 1'b0};
    tv[15] = '{4'hA, 4'h0, 1'b0, 4'h0, 2'd0, 4'd0, 1'b0};
    tv[16] = '{4'h0, 4'hF, 1'b0, 4'h0, 2'd0, 4'd0, 1'b0};
    tv[17] = '{4'h8, 4'hF, 1'b0, 4'h8, 2'd3, 4'd1, 1'b0};
    tv[18] = '{4'h8, 4'hF, 1'b1, 4'h0, 2'd0, 4'd0, 1'b0};
    tv[19] = '{4'h9, 4'hF, 1'b0, 4'h1, 2'd0, 4'd1, 1'b0};
    tv[20] = '{4'h9, 4'hF, 1'b1, 4'h0, 2'd0, 4'd0, 1'b0};
    tv[21] = '{4'h4, 4'hF, 1'b0, 4'h4, 2'd2, 4'd1, 1'b0};
    tv[22] = '{4'h0, 4'hF, 1'b0, 4'h0, 2'd0, 4'd0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk_main("reset", 4'h0, 2'd0, 4'd0, 1'b0);
    chk("reset.grant1", 32'(grant1), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 23; i++) begin
      req = tv[i].req;
      mask = tv[i].mask;
      done = tv[i].done;
      tick();
      chk_main($sformatf("vec%0d", i), tv[i].g, tv[i].id, tv[i].h, tv[i].to);
    end
    // hold limit: forced release, one-cycle timeout pulse, then re-grant
    @(negedge clk);
    rst = 1'b1;
    req = 4'h1;
    mask = 4'hF;
    done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk_main($sformatf("hold%0d", c), 4'h1, 2'd0, 4'(c), 1'b0);
      chk($sformatf("mh1.grant%0d", c), 32'(grant1), (c % 2) ? 32'h1 : 32'h0);
      chk($sformatf("mh1.timeout%0d", c), 32'(timeout1), (c % 2) ? 32'h0 : 32'h1);
    end
    tick();
    chk_main("forced", 4'h0, 2'd0, 4'd0, 1'b1);
    tick();
    chk_main("regrant", 4'h1, 2'd0, 4'd1, 1'b0);
    for (int c = 2; c <= 8; c++) tick();
    chk("hold8b", 32'(hold_cnt), 32'd8);
    done = 1'b1;
    tick();
    chk_main("done_at_max", 4'h0, 2'd0, 4'd0, 1'b0);
    done = 1'b0;
    tick();
    chk_main("pre_rst", 4'h1, 2'd0, 4'd1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_main("async_rst", 4'h0, 2'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'hC;
    tick();
    chk_main("after_rst", 4'h4, 2'd2, 4'd1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
